// File: rtl/change_dispense_if.sv
// change_dispense_if: vend-FSM/hopper handshake bundle for the change dispenser
// master: vending FSM and hoppers (drive start/paid/price/refill/hop_ack)
// slave: change_dispense_ctrl (drives hop_fire, status and inventory flags)
interface change_dispense_if;
  logic       start;
  logic [7:0] paid;
  logic [7:0] price;
  logic       refill;
  logic [2:0] hop_ack;
  logic [2:0] hop_fire;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] err_code;
  logic [7:0] change_due;
  logic [2:0] inv_empty;
  modport master (
    output start, paid, price, refill, hop_ack,
    input  hop_fire, busy, done, fault, err_code, change_due, inv_empty
  );
  modport slave (
    input  start, paid, price, refill, hop_ack,
    output hop_fire, busy, done, fault, err_code, change_due, inv_empty
  );
endinterface

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: greedy $10/$5/$1 change dispensing over fire/ack hoppers
// Ports: clk; reset (async, active-low); bus (change_dispense_if.slave) carrying
//   start/paid/price/refill/hop_ack in and hop_fire/busy/done/fault/err_code/
//   change_due/inv_empty out. Hopper bit order is [2]=$10 [1]=$5 [0]=$1.
module change_dispense_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255,
  parameter int INV_INIT     = 20
) (
  input logic clk,
  input logic reset,
  change_dispense_if.slave bus
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CALC, SELECT, FIRE, WAIT_ACK, DONE, FAULT} state_t;
  state_t        state;
  logic [7:0]    paid_q, price_q;
  logic [7:0]    inv [3];
  logic [1:0]    sel, pick;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    coin;
  logic          c10, c5, c1, ack, tmo;
  // change_due is nonzero whenever a pick is used, so $1 only needs stock
  assign c10  = bus.change_due >= 8'd10 && inv[2] != 8'd0;
  assign c5   = bus.change_due >= 8'd5 && inv[1] != 8'd0;
  assign c1   = inv[0] != 8'd0;
  assign pick = c10 ? 2'd2 : c5 ? 2'd1 : 2'd0;
  assign coin = sel == 2'd2 ? 8'd10 : sel == 2'd1 ? 8'd5 : 8'd1;
  assign ack  = bus.hop_ack[sel];
  // counter is 0 in the first FIRE cycle, so fault lands ACK_TIMEOUT cycles later
  assign tmo  = tcnt == TW'(ACK_TIMEOUT - 1);
  assign bus.inv_empty = {inv[2] == 8'd0, inv[1] == 8'd0, inv[0] == 8'd0};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.hop_fire   <= 3'b000;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.fault      <= 1'b0;
      bus.err_code   <= 2'b00;
      bus.change_due <= 8'd0;
      paid_q         <= 8'd0;
      price_q        <= 8'd0;
      sel            <= 2'd0;
      pcnt           <= '0;
      tcnt           <= '0;
      for (int i = 0; i < 3; i++) inv[i] <= 8'(INV_INIT);
    end else begin
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.refill) for (int i = 0; i < 3; i++) inv[i] <= 8'(INV_INIT);
          if (bus.start) begin
            paid_q       <= bus.paid;
            price_q      <= bus.price;
            bus.err_code <= 2'b00;
            bus.busy     <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          if (paid_q < price_q) begin
            bus.err_code <= 2'b01;
            bus.fault    <= 1'b1;
            state        <= FAULT;
          end else begin
            bus.change_due <= paid_q - price_q;
            state          <= SELECT;
          end
        end
        SELECT: begin
          if (bus.change_due == 8'd0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (c10 || c5 || c1) begin
            sel          <= pick;
            bus.hop_fire <= 3'b001 << pick;
            pcnt         <= '0;
            tcnt         <= '0;
            state        <= FIRE;
          end else begin
            bus.err_code <= 2'b10;
            bus.fault    <= 1'b1;
            state        <= FAULT;
          end
        end
        FIRE, WAIT_ACK: begin
          // an ack during the pulse is taken at once and cuts the pulse short
          if (ack) begin
            bus.change_due <= bus.change_due - coin;
            inv[sel]       <= inv[sel] - 8'd1;
            bus.hop_fire   <= 3'b000;
            state          <= SELECT;
          end else if (tmo) begin
            bus.err_code <= 2'b11;
            bus.fault    <= 1'b1;
            bus.hop_fire <= 3'b000;
            state        <= FAULT;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (state == FIRE) begin
              pcnt <= pcnt + PW'(1);
              if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                bus.hop_fire <= 3'b000;
                state        <= WAIT_ACK;
              end
            end
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb_change_dispense_ctrl: directed + randomized check of change_dispense_ctrl against a greedy change model
module tb_change_dispense_ctrl;
  localparam int P = 4, AT = 255, INIT = 20;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int minv[3];
  change_dispense_if bus();
  change_dispense_ctrl #(.PULSE_CYCLES(P), .ACK_TIMEOUT(AT), .INV_INIT(INIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int val(input int i);
    return i == 2 ? 10 : i == 1 ? 5 : 1;
  endfunction
  function automatic logic [2:0] empty_model();
    return {minv[2] == 0, minv[1] == 0, minv[0] == 0};
  endfunction
  task automatic model_refill;
    for (int i = 0; i < 3; i++) minv[i] = INIT;
  endtask
  // one transaction: the model predicts coins and outcome, the bench acts as hoppers
  task automatic txn(input int p, input int q, input bit refill_mid);
    int exp_q[$];
    int got[$];
    int c, eerr, cyc, k, w, d;
    bit ok;
    logic [2:0] fired;
    c = 0;
    eerr = 0;
    if (p < q) eerr = 1;
    else begin
      c = p - q;
      while (c > 0) begin
        d = -1;
        for (int i = 2; i >= 0; i--) if (d < 0 && val(i) <= c && minv[i] > 0) d = i;
        if (d < 0) break;
        exp_q.push_back(val(d));
        c -= val(d);
        minv[d]--;
      end
      if (c > 0) eerr = 2;
    end
    bus.paid = 8'(p);
    bus.price = 8'(q);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    chk("err_cleared", bus.err_code, 0);
    cyc = 0;
    while (!(bus.done || bus.fault) && cyc < 500) begin
      if (bus.hop_fire != 3'b000) begin
        fired = bus.hop_fire;
        chk("fire_onehot", $onehot(fired), 1);
        got.push_back(fired[2] ? 10 : fired[1] ? 5 : 1);
        k = (refill_mid && got.size() == 1) ? $urandom_range(1, P + 3) : $urandom_range(0, P + 3);
        w = 0;
        for (int i = 0; i < k; i++) begin
          if (bus.hop_fire == fired) w++;
          bus.hop_ack = 3'($urandom) & ~fired;
          bus.refill = refill_mid && i == 0 && got.size() == 1;
          step;
        end
        bus.refill = 1'b0;
        if (bus.hop_fire == fired) w++;
        bus.hop_ack = fired;
        step;
        bus.hop_ack = 3'b000;
        chk("pulse_width", w, (k + 1 < P) ? k + 1 : P);
        cyc += k + 1;
      end else begin
        step;
        cyc++;
      end
    end
    chk("txn_end", bus.done | bus.fault, 1);
    chk("done_vs_fault", bus.done, eerr == 0);
    chk("err_code", bus.err_code, eerr);
    if (eerr != 1) chk("change_due", bus.change_due, c);
    ok = got.size() == exp_q.size();
    for (int i = 0; i < got.size(); i++) if (ok && got[i] != exp_q[i]) ok = 1'b0;
    chk("coin_count", got.size(), exp_q.size());
    chk("coin_seq", ok, 1);
    step;
    chk("idle_busy", bus.busy, 0);
    chk("idle_pulse", bus.done | bus.fault, 0);
    chk("inv_empty", bus.inv_empty, empty_model());
  endtask
  initial begin
    int p, q, n;
    bus.start = 1'b0;
    bus.paid = 8'd0;
    bus.price = 8'd0;
    bus.refill = 1'b0;
    bus.hop_ack = 3'b000;
    model_refill();
    step;
    chk("rst_fire", bus.hop_fire, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_err", bus.err_code, 0);
    chk("rst_change", bus.change_due, 0);
    chk("rst_inv_empty", bus.inv_empty, 0);
    reset = 1'b1;
    step;
    txn(20, 6, 1'b0);
    bus.paid = 8'd5;
    bus.price = 8'd10;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    chk("under_busy1", bus.busy, 1);
    chk("under_fault_early", bus.fault, 0);
    step;
    chk("under_fault", bus.fault, 1);
    chk("under_err", bus.err_code, 1);
    chk("under_busy2", bus.busy, 1);
    chk("under_fire", bus.hop_fire, 0);
    step;
    chk("under_busy_end", bus.busy, 0);
    chk("under_err_hold", bus.err_code, 1);
    bus.paid = 8'd7;
    bus.price = 8'd7;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    chk("lat_err_clear", bus.err_code, 0);
    chk("lat_done_n0", bus.done, 0);
    step;
    chk("lat_done_n1", bus.done, 0);
    step;
    chk("lat_done_n2", bus.done, 1);
    chk("lat_change", bus.change_due, 0);
    step;
    chk("lat_done_off", bus.done, 0);
    chk("lat_busy_off", bus.busy, 0);
    txn(190, 0, 1'b0);
    txn(20, 6, 1'b1);
    txn(90, 0, 1'b0);
    txn(9, 0, 1'b0);
    txn(9, 0, 1'b0);
    bus.refill = 1'b1;
    step;
    bus.refill = 1'b0;
    model_refill();
    chk("refill_idle", bus.inv_empty, 0);
    txn(9, 0, 1'b0);
    n = 0;
    repeat (6) begin
      q = $urandom_range(0, 60);
      p = ($urandom_range(0, 4) == 0) ? $urandom_range(0, q) : q + $urandom_range(0, 45);
      txn(p, q, 1'b0);
      n++;
    end
    bus.refill = 1'b1;
    step;
    bus.refill = 1'b0;
    model_refill();
    bus.paid = 8'd1;
    bus.price = 8'd0;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    step;
    step;
    chk("tmo_fire", bus.hop_fire, 3'b001);
    repeat (AT - 1) step;
    chk("tmo_early", bus.fault, 0);
    step;
    chk("tmo_fault", bus.fault, 1);
    chk("tmo_err", bus.err_code, 3);
    chk("tmo_change", bus.change_due, 1);
    chk("tmo_fire_off", bus.hop_fire, 0);
    step;
    chk("tmo_idle", bus.busy, 0);
    txn(65, 0, 1'b0);
    bus.paid = 8'd3;
    bus.price = 8'd0;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    n = 0;
    while (bus.hop_fire == 3'b000 && n < 10) begin
      step;
      n++;
    end
    chk("rst_mid_fire_seen", bus.hop_fire, 3'b001);
    reset = 1'b0;
    #1;
    chk("rst_mid_fire", bus.hop_fire, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_inv", bus.inv_empty, 0);
    chk("rst_mid_change", bus.change_due, 0);
    reset = 1'b1;
    model_refill();
    step;
    txn(250, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
